// File: rtl/modulo_resolvedor_ataque.sv
// Attack resolver for the naval-battle board: checks, records and acknowledges shots.
// Optional shot limit: define ATTACK_LIMIT_EN so reaching MAX_SHOTS without sinking everything ends the game as a loss.
module modulo_resolvedor_ataque #(
  parameter int N_LIN       = 7,
  parameter int N_COL       = 5,
  parameter int BLINK_TICKS = 3,
  parameter int MAX_SHOTS   = 15
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   tick,
  input  logic                   load,
  input  logic [N_LIN*N_COL-1:0] m_po,
  input  logic                   at_req,
  input  logic [2:0]             at_lin,
  input  logic [2:0]             at_col,
  output logic                   at_ack,
  output logic [1:0]             at_res,
  output logic [N_LIN*N_COL-1:0] m_at,
  output logic [N_LIN*N_COL-1:0] m_hit,
  output logic [5:0]             hits,
  output logic [5:0]             shots,
  output logic                   game_over,
  output logic                   win,
  output logic [1:0]             rgb,
  output logic [2:0]             fsm_state
);
  localparam int NC = N_LIN * N_COL;
  localparam int IW = $clog2(NC);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  // fsm_state exposes this encoding: IDLE=0 ARMED=1 CHECK=2 WRITE=3 OVER=4
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    CHECK = 3'd2,
    WRITE = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [1:0] RES_MISS = 2'b01;
  localparam logic [1:0] RES_HIT  = 2'b10;
  localparam logic [1:0] RES_INV  = 2'b11;

  state_t        state;
  logic [NC-1:0] board;
  logic [5:0]    ship_cells;
  logic [2:0]    lin_q;
  logic [2:0]    col_q;
  logic [1:0]    res_q;
  logic [IW-1:0] idx_q;
  logic [BW-1:0] blink_cnt;

  logic          in_range;
  logic [IW-1:0] cell_idx;
  logic [5:0]    hits_next;
  logic [5:0]    shots_next;
  logic          done_win;
  logic          done_limit;

  // cell_idx is only meaningful when in_range; out-of-range values are never used to index
  always_comb begin
    in_range   = (int'(lin_q) < N_LIN) && (int'(col_q) < N_COL);
    cell_idx   = IW'(NC - 1 - N_COL * int'(lin_q) - int'(col_q));
    hits_next  = hits + 6'(res_q == RES_HIT);
    shots_next = shots + 6'(res_q != RES_INV);
    done_win   = (hits_next == ship_cells);
  end

`ifdef ATTACK_LIMIT_EN
  assign done_limit = (res_q != RES_INV) && (shots_next == 6'(MAX_SHOTS));
`else
  logic unused_limit;
  assign unused_limit = ^6'(MAX_SHOTS);
  assign done_limit   = 1'b0;
`endif

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      board      <= '0;
      ship_cells <= '0;
      lin_q      <= '0;
      col_q      <= '0;
      res_q      <= '0;
      idx_q      <= '0;
      blink_cnt  <= '0;
      at_ack     <= 1'b0;
      at_res     <= '0;
      m_at       <= '0;
      m_hit      <= '0;
      hits       <= '0;
      shots      <= '0;
      game_over  <= 1'b0;
      win        <= 1'b0;
      rgb        <= '0;
    end else begin
      at_ack <= 1'b0;
      // Feedback timeout; an ack or load below overrides this on the same edge
      if (tick && blink_cnt != '0) begin
        blink_cnt <= blink_cnt - 1'b1;
        if (blink_cnt == BW'(1)) rgb <= 2'b00;
      end

      if (load) begin
        board      <= m_po;
        ship_cells <= 6'($countones(m_po));
        m_at       <= '0;
        m_hit      <= '0;
        hits       <= '0;
        shots      <= '0;
        at_res     <= '0;
        rgb        <= '0;
        blink_cnt  <= '0;
        if (m_po == '0) begin
          state     <= OVER;
          game_over <= 1'b1;
          win       <= 1'b1;
        end else begin
          state     <= ARMED;
          game_over <= 1'b0;
          win       <= 1'b0;
        end
      end else begin
        case (state)
          ARMED: begin
            if (at_req) begin
              lin_q <= at_lin;
              col_q <= at_col;
              state <= CHECK;
            end
          end
          CHECK: begin
            idx_q <= cell_idx;
            if (!in_range || m_at[cell_idx]) res_q <= RES_INV;
            else if (board[cell_idx])        res_q <= RES_HIT;
            else                             res_q <= RES_MISS;
            state <= WRITE;
          end
          WRITE: begin
            at_ack    <= 1'b1;
            at_res    <= res_q;
            rgb       <= {res_q[0], res_q[1]};
            blink_cnt <= BW'(BLINK_TICKS);
            if (res_q != RES_INV) begin
              m_at[idx_q] <= 1'b1;
              shots       <= shots_next;
            end
            if (res_q == RES_HIT) begin
              m_hit[idx_q] <= 1'b1;
              hits         <= hits_next;
            end
            if (done_win) begin
              state     <= OVER;
              game_over <= 1'b1;
              win       <= 1'b1;
            end else if (done_limit) begin
              state     <= OVER;
              game_over <= 1'b1;
              win       <= 1'b0;
            end else begin
              state <= ARMED;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
